// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file.
package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for the register file: one pending-write bit per register.
// A reservation from decode and a writeback release of the same register
// in the same cycle leave the bit set, because the new writer is still
// outstanding. RF_BYPASS_EN masks rbusy for a register being forwarded.
module rf_scoreboard #(
   parameter int  NREGS        = 32,
   parameter int  NREAD        = 2,
   parameter bit  RF_BYPASS_EN = 1'b0,
   localparam int AW           = $clog2(NREGS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wen,
   input  logic [AW-1:0]             wa,
   input  logic                      set_en,
   input  logic [AW-1:0]             set_addr,
   input  logic [NREAD-1:0][AW-1:0]  ra,
   output logic [NREAD-1:0]          rbusy,
   output logic [NREGS-1:0]          busy_vec
);

   logic [NREGS-1:0] busy;

   // Clear on writeback first, then set, so a same-cycle set wins.
   // Register 0 is never set, so its bit stays 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (wen)
            busy[wa] <= 1'b0;
         if (set_en && (set_addr != '0))
            busy[set_addr] <= 1'b1;
      end
   end

   // Per-port hazard flag, masked when the data is forwarded this cycle.
   always_comb begin
      rbusy = '0;
      for (int k = 0; k < NREAD; k++) begin
         rbusy[k] = busy[ra[k]];
         if (RF_BYPASS_EN && wen && (wa != '0) && (ra[k] == wa))
            rbusy[k] = 1'b0;
      end
   end

   assign busy_vec = busy;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with hardwired-zero x0,
// asynchronous clear and a busy scoreboard for RAW hazard detection.
// Optional macro RF_BYPASS_EN: forward same-cycle writeback data to reads.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int  XLEN  = XLEN_DEF,
   parameter int  NREGS = NREGS_DEF,
   parameter int  NREAD = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wen,
   input  logic [AW-1:0]              wa,
   input  logic [XLEN-1:0]            wd,
   input  logic [NREAD-1:0][AW-1:0]   ra,
   output logic [NREAD-1:0][XLEN-1:0] rd,
   output logic [NREAD-1:0]           rbusy,
   input  logic                       set_en,
   input  logic [AW-1:0]              set_addr,
   output logic [NREGS-1:0]           busy_vec
);

`ifdef RF_BYPASS_EN
   localparam bit BYPASS_ON = 1'b1;
`else
   localparam bit BYPASS_ON = 1'b0;
`endif

   logic [XLEN-1:0] regs [NREGS];

   // Storage array; writes to x0 are dropped so it keeps its reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wen && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   // Read muxes; x0 is forced to zero independently of the array contents.
   always_comb begin
      rd = '0;
      for (int k = 0; k < NREAD; k++) begin
         if (ra[k] != '0)
            rd[k] = regs[ra[k]];
`ifdef RF_BYPASS_EN
         // Gated by rst_n so a held writeback cannot leak through during reset.
         if (rst_n && wen && (wa != '0) && (ra[k] == wa))
            rd[k] = wd;
`endif
      end
   end

   rf_scoreboard #(
      .NREGS        (NREGS),
      .NREAD        (NREAD),
      .RF_BYPASS_EN (BYPASS_ON)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .wen      (wen),
      .wa       (wa),
      .set_en   (set_en),
      .set_addr (set_addr),
      .ra       (ra),
      .rbusy    (rbusy),
      .busy_vec (busy_vec)
   );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed and model-checked bench for register_file_mp (32x2 and 16x4 builds).
module tb_register_file_mp;
   import rf_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Default build: 32 registers, 2 read ports
   logic             wen, set_en;
   reg_addr_t        wa, set_addr;
   xlen_t            wd;
   logic [1:0][4:0]  ra;
   logic [1:0][31:0] rd;
   logic [1:0]       rbusy;
   logic [31:0]      busy_vec;

   // Second build: 16 registers, 4 read ports
   logic             wen4, set_en4;
   logic [3:0]       wa4, set_addr4;
   logic [31:0]      wd4;
   logic [3:0][3:0]  ra4;
   logic [3:0][31:0] rd4;
   logic [3:0]       rbusy4;
   logic [15:0]      busy_vec4;

   register_file_mp u_dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
      .rbusy(rbusy), .set_en(set_en), .set_addr(set_addr), .busy_vec(busy_vec)
   );

   register_file_mp #(.NREGS(16), .NREAD(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .wen(wen4), .wa(wa4), .wd(wd4), .ra(ra4), .rd(rd4),
      .rbusy(rbusy4), .set_en(set_en4), .set_addr(set_addr4), .busy_vec(busy_vec4)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        set_en;
      logic [4:0]  set_addr;
      logic [4:0]  ra0, ra1;
      logic [31:0] e_rd0, e_rd1;
      logic [1:0]  e_rbusy;
      logic [31:0] e_busy;
   } vec_t;

   function automatic vec_t mk(input int w, input int a, input logic [31:0] d,
                               input int se, input int sa, input int r0, input int r1,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input int eb, input logic [31:0] ebusy);
      vec_t v;
      v.wen = 1'(w);       v.wa = 5'(a);        v.wd = d;
      v.set_en = 1'(se);   v.set_addr = 5'(sa);
      v.ra0 = 5'(r0);      v.ra1 = 5'(r1);
      v.e_rd0 = e0;        v.e_rd1 = e1;
      v.e_rbusy = 2'(eb);  v.e_busy = ebusy;
      return v;
   endfunction

   vec_t vt[14];

   // Reference model for the 16x4 build
   logic [31:0] mreg [16];
   logic [15:0] mbusy;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Expected values assume the sweep state reg[i] = i*0x1111, busy = 0.
      vt[0]  = mk(0, 0, 0, 1, 7,   7, 3,  32'h7777, 32'h3333, 0, 32'h0);
      vt[1]  = mk(0, 0, 0, 0, 0,   7, 0,  32'h7777, 32'h0, 1, 32'h80);
      vt[2]  = mk(1, 7, 32'h12345678, 1, 7,  3, 9,  32'h3333, 32'h9999, 0, 32'h80);
      vt[3]  = mk(0, 0, 0, 0, 0,   7, 7,  32'h12345678, 32'h12345678, 3, 32'h80);
      vt[4]  = mk(1, 7, 32'h0BADF00D, 0, 0,  1, 2,  32'h1111, 32'h2222, 0, 32'h80);
      vt[5]  = mk(0, 0, 0, 0, 0,   7, 0,  32'h0BADF00D, 32'h0, 0, 32'h0);
      vt[6]  = mk(1, 0, 32'hDEADBEEF, 1, 0,  0, 31, 32'h0, 32'h1111 * 31, 0, 32'h0);
      vt[7]  = mk(0, 0, 0, 0, 0,   0, 0,  32'h0, 32'h0, 0, 32'h0);
      vt[8]  = mk(1, 12, 32'hCAFE0000, 1, 12,  4, 5,  32'h4444, 32'h5555, 0, 32'h0);
      vt[9]  = mk(0, 0, 0, 1, 12,  12, 7, 32'hCAFE0000, 32'h0BADF00D, 1, 32'h1000);
      vt[10] = mk(1, 12, 32'h12, 0, 0,  6, 8,  32'h6666, 32'h8888, 0, 32'h1000);
      vt[11] = mk(0, 0, 0, 0, 0,   12, 12, 32'h12, 32'h12, 0, 32'h0);
      vt[12] = mk(1, 20, 32'h1, 0, 0,  19, 21, 32'h1111 * 19, 32'h1111 * 21, 0, 32'h0);
      vt[13] = mk(0, 0, 0, 0, 0,   20, 21, 32'h1, 32'h1111 * 21, 0, 32'h0);

      wen = 0; wa = '0; wd = '0; set_en = 0; set_addr = '0; ra = '0;
      wen4 = 0; wa4 = '0; wd4 = '0; set_en4 = 0; set_addr4 = '0; ra4 = '0;

      // Reset held for three cycles
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      ra[0] = 5'd5; ra[1] = 5'd31;
      #1;
      check("rst_rd0", 64'(rd[0]), 64'h0);
      check("rst_rd1", 64'(rd[1]), 64'h0);
      check("rst_rbusy", 64'(rbusy), 64'h0);
      check("rst_busy_vec", 64'(busy_vec), 64'h0);
      rst_n = 1;

      // Sweep: write i*0x1111 to every register, read back on both ports
      for (int i = 1; i < 32; i++) begin
         wen = 1; wa = 5'(i); wd = 32'(i) * 32'h1111;
         step();
      end
      wen = 0;
      for (int i = 1; i < 32; i++) begin
         ra[0] = 5'(i); ra[1] = 5'(i);
         #1;
         check($sformatf("sweep_rd0_r%0d", i), 64'(rd[0]), 64'(32'(i) * 32'h1111));
         check($sformatf("sweep_rd1_r%0d", i), 64'(rd[1]), 64'(32'(i) * 32'h1111));
      end

      // Table: scoreboard, x0 handling, set/clear priority
      step();
      for (int n = 0; n < 14; n++) begin
         wen = vt[n].wen; wa = vt[n].wa; wd = vt[n].wd;
         set_en = vt[n].set_en; set_addr = vt[n].set_addr;
         ra[0] = vt[n].ra0; ra[1] = vt[n].ra1;
         #1;
         check($sformatf("v%0d_rd0", n), 64'(rd[0]), 64'(vt[n].e_rd0));
         check($sformatf("v%0d_rd1", n), 64'(rd[1]), 64'(vt[n].e_rd1));
         check($sformatf("v%0d_rbusy", n), 64'(rbusy), 64'(vt[n].e_rbusy));
         check($sformatf("v%0d_busy_vec", n), 64'(busy_vec), 64'(vt[n].e_busy));
         step();
      end
      wen = 0; set_en = 0;

      // Same-cycle write and read of r5, with r5 reserved
      set_en = 1; set_addr = 5'd5;
      step();
      set_en = 0;
      wen = 1; wa = 5'd5; wd = 32'hA5A5A5A5; ra[0] = 5'd6; ra[1] = 5'd5;
      #1;
      check("byp_rd0", 64'(rd[0]), 64'h6666);
      check("byp_busy_vec", 64'(busy_vec), 64'h20);
`ifdef RF_BYPASS_EN
      check("byp_rd1_same", 64'(rd[1]), 64'hA5A5A5A5);
      check("byp_rbusy_same", 64'(rbusy), 64'h0);
`else
      check("byp_rd1_same", 64'(rd[1]), 64'h5555);
      check("byp_rbusy_same", 64'(rbusy), 64'h2);
`endif
      step();
      wen = 0;
      #1;
      check("byp_rd1_next", 64'(rd[1]), 64'hA5A5A5A5);
      check("byp_rbusy_next", 64'(rbusy), 64'h0);
      check("byp_busy_vec_next", 64'(busy_vec), 64'h0);

      // Fill with all-ones and reserve every register, then reset mid-cycle
      for (int i = 1; i < 32; i++) begin
         wen = 1; wa = 5'(i); wd = 32'hFFFFFFFF;
         set_en = 1; set_addr = 5'(i);
         step();
      end
      wen = 0; set_en = 0;
      ra[0] = 5'd3; ra[1] = 5'd31;
      #1;
      check("full_rd0", 64'(rd[0]), 64'hFFFFFFFF);
      check("full_busy_vec", 64'(busy_vec), 64'hFFFFFFFE);
      check("full_rbusy", 64'(rbusy), 64'h3);
      wen = 1; wa = 5'd3; wd = 32'h1234;
      #2;
      rst_n = 0;
      #1;
      check("midrst_rd0", 64'(rd[0]), 64'h0);
      check("midrst_rd1", 64'(rd[1]), 64'h0);
      check("midrst_busy_vec", 64'(busy_vec), 64'h0);
      check("midrst_rbusy", 64'(rbusy), 64'h0);
      step();
      wen = 0;
      rst_n = 1;
      #1;
      check("lost_write_rd0", 64'(rd[0]), 64'h0);
      wen = 1; wa = 5'd3; wd = 32'h1234;
      step();
      wen = 0;
      #1;
      check("first_write_rd0", 64'(rd[0]), 64'h1234);
      check("first_write_rd1", 64'(rd[1]), 64'h0);

      // 16x4 build against the reference model (it was cleared by the reset above)
      for (int i = 0; i < 16; i++) mreg[i] = '0;
      mbusy = '0;
      for (int c = 0; c < 1000; c++) begin
         logic [3:0] base;
         wen4 = 1'($urandom_range(0, 1));
         wa4 = 4'($urandom_range(0, 15));
         wd4 = $urandom;
         set_en4 = ($urandom_range(0, 3) == 0);
         set_addr4 = 4'($urandom_range(0, 15));
         base = 4'($urandom_range(0, 15));
         for (int k = 0; k < 4; k++) begin
            if (c < 200)      ra4[k] = base;
            else if (c < 400) ra4[k] = base + 4'(k);
            else              ra4[k] = 4'($urandom_range(0, 15));
         end
         #1;
         for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            logic        eb;
            e  = (ra4[k] == 4'd0) ? 32'h0 : mreg[ra4[k]];
            eb = mbusy[ra4[k]];
`ifdef RF_BYPASS_EN
            if (wen4 && (wa4 != 4'd0) && (ra4[k] == wa4)) begin
               e = wd4;
               eb = 1'b0;
            end
`endif
            check($sformatf("m4_c%0d_rd%0d", c, k), 64'(rd4[k]), 64'(e));
            check($sformatf("m4_c%0d_rbusy%0d", c, k), 64'(rbusy4[k]), 64'(eb));
         end
         check($sformatf("m4_c%0d_busy_vec", c), 64'(busy_vec4), 64'(mbusy));
         step();
         if (wen4 && (wa4 != 4'd0)) mreg[wa4] = wd4;
         if (wen4) mbusy[wa4] = 1'b0;
         if (set_en4 && (set_addr4 != 4'd0)) mbusy[set_addr4] = 1'b1;
      end
      wen4 = 0; set_en4 = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
